// File: rtl/pixel_color_pipe.sv
// Pixel colour stage behind the rect-priority mux tree: colour RAM lookup, background/blank select.
// Optional per-frame hit counter enabled by defining GPU_HIT_COUNT_EN.
`ifndef RECT_COUNT
`define RECT_COUNT 12
`endif
`ifndef RECT_COUNT_WIDTH
`define RECT_COUNT_WIDTH 4
`endif

module pixel_color_pipe #(
   parameter int RECT_COUNT       = `RECT_COUNT,
   parameter int RECT_COUNT_WIDTH = `RECT_COUNT_WIDTH,
   parameter int COLOR_WIDTH      = 16,
   parameter int HIT_CNT_WIDTH    = 20
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        frame_start,
   input  logic [COLOR_WIDTH-1:0]      bg_color,
   input  logic                        pix_valid_in,
   input  logic                        hit_flag,
   input  logic [RECT_COUNT_WIDTH-1:0] hit_index,
   input  logic                        blank,
   output logic [RECT_COUNT_WIDTH-1:0] color_addr,
   input  logic [COLOR_WIDTH-1:0]      color_data,
   output logic                        pix_valid_out,
   output logic [COLOR_WIDTH-1:0]      pixel_color,
   output logic [HIT_CNT_WIDTH-1:0]    hit_count
);

   localparam logic [RECT_COUNT_WIDTH:0] RECT_LIMIT = (RECT_COUNT_WIDTH+1)'(RECT_COUNT);

   // Each pixel carries its own background copy so a frame_start cannot recolour in-flight pixels.
   typedef struct packed {
      logic                   valid;
      logic                   hit;
      logic                   blank;
      logic [COLOR_WIDTH-1:0] bg;
   } stage_t;

   stage_t                      s1_q, s1_d, s2_q, s2_d;
   logic [COLOR_WIDTH-1:0]      bg_q, bg_d;
   logic [RECT_COUNT_WIDTH-1:0] addr_q, addr_d;
   logic                        vout_q, vout_d;
   logic [COLOR_WIDTH-1:0]      color_q, color_d;

   always_comb begin
      bg_d        = frame_start ? bg_color : bg_q;
      s1_d.valid  = pix_valid_in;
      s1_d.hit    = pix_valid_in && hit_flag && ({1'b0, hit_index} < RECT_LIMIT);
      s1_d.blank  = blank;
      s1_d.bg     = bg_d;
      addr_d      = s1_d.hit ? hit_index : addr_q;
      s2_d        = s1_q;
      vout_d      = s2_q.valid;
      color_d     = color_q;
      if (s2_q.valid)
         color_d = s2_q.blank ? '0 : (s2_q.hit ? color_data : s2_q.bg);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_q    <= '0;
         s2_q    <= '0;
         bg_q    <= '0;
         addr_q  <= '0;
         vout_q  <= 1'b0;
         color_q <= '0;
      end else begin
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         bg_q    <= bg_d;
         addr_q  <= addr_d;
         vout_q  <= vout_d;
         color_q <= color_d;
      end
   end

   assign color_addr    = addr_q;
   assign pix_valid_out = vout_q;
   assign pixel_color   = color_q;

`ifdef GPU_HIT_COUNT_EN
   logic                     s3_cnt_q, s3_cnt_d;
   logic [HIT_CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc, hc_q, hc_d;

   // cnt_inc includes the pixel retiring this cycle, so a frame_start never drops it.
   always_comb begin
      s3_cnt_d = s2_q.valid && s2_q.hit && !s2_q.blank;
      cnt_inc  = (s3_cnt_q && (cnt_q != '1)) ? cnt_q + HIT_CNT_WIDTH'(1) : cnt_q;
      cnt_d    = frame_start ? '0 : cnt_inc;
      hc_d     = frame_start ? cnt_inc : hc_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s3_cnt_q <= 1'b0;
         cnt_q    <= '0;
         hc_q     <= '0;
      end else begin
         s3_cnt_q <= s3_cnt_d;
         cnt_q    <= cnt_d;
         hc_q     <= hc_d;
      end
   end

   assign hit_count = hc_q;
`else
   assign hit_count = '0;
`endif

endmodule

// File: tb/tb_pixel_color_pipe.sv
// Directed bench for pixel_color_pipe: per-cycle vector table plus reset and hit-count sequences.
module tb_pixel_color_pipe;

   localparam int RC = 12;
   localparam int IW = 4;
   localparam int CW = 16;
   localparam int HW = 20;

   logic          clk = 1'b0;
   logic          reset;
   logic          frame_start;
   logic [CW-1:0] bg_color;
   logic          pix_valid_in;
   logic          hit_flag;
   logic [IW-1:0] hit_index;
   logic          blank;
   logic [IW-1:0] color_addr;
   logic [CW-1:0] color_data;
   logic          pix_valid_out;
   logic [CW-1:0] pixel_color;
   logic [HW-1:0] hit_count;

   int total = 0;
   int bad   = 0;

   pixel_color_pipe #(.RECT_COUNT(RC), .RECT_COUNT_WIDTH(IW), .COLOR_WIDTH(CW), .HIT_CNT_WIDTH(HW)) dut (
      .clk(clk), .reset(reset), .frame_start(frame_start), .bg_color(bg_color),
      .pix_valid_in(pix_valid_in), .hit_flag(hit_flag), .hit_index(hit_index), .blank(blank),
      .color_addr(color_addr), .color_data(color_data), .pix_valid_out(pix_valid_out),
      .pixel_color(pixel_color), .hit_count(hit_count));

   always #5 clk = ~clk;

   // Synchronous colour RAM model, one-cycle read.
   logic [CW-1:0] ram [16];
   initial begin
      for (int i = 0; i < 16; i++) ram[i] = 16'hA000 + 16'(i);
      ram[1] = 16'h0001;
      ram[2] = 16'h0002;
      ram[5] = 16'hF800;
   end
   always @(posedge clk) color_data <= ram[color_addr];

   typedef struct {
      logic          fs;
      logic [CW-1:0] bg;
      logic          v;
      logic          hit;
      logic [IW-1:0] idx;
      logic          blk;
      logic [CW-1:0] exp;
   } vec_t;

   localparam int N = 20;
   vec_t tv [N];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t t);
      frame_start  = t.fs;
      bg_color     = t.bg;
      pix_valid_in = t.v;
      hit_flag     = t.hit;
      hit_index    = t.idx;
      blank        = t.blk;
   endtask

   task automatic idle();
      frame_start  = 1'b0;
      pix_valid_in = 1'b0;
      hit_flag     = 1'b0;
      blank        = 1'b0;
   endtask

   task automatic pix(input logic h, input logic [IW-1:0] i, input logic b);
      frame_start  = 1'b0;
      pix_valid_in = 1'b1;
      hit_flag     = h;
      hit_index    = i;
      blank        = b;
   endtask

   initial begin
      logic [IW-1:0] ea;
      logic [CW-1:0] last_col;
      //              fs    bg        v     hit   idx   blk   expected colour
      tv[0]  = '{1'b1, 16'h001F, 1'b0, 1'b0, 4'd0,  1'b0, 16'h0000};
      tv[1]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd0,  1'b0, 16'h001F};
      tv[2]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd3,  1'b0, 16'h001F};
      tv[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd0,  1'b0, 16'h001F};
      tv[4]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd0,  1'b0, 16'h001F};
      tv[5]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 4'd5,  1'b0, 16'hF800};
      tv[6]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 4'd1,  1'b0, 16'h0001};
      tv[7]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 4'd2,  1'b0, 16'h0002};
      tv[8]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 4'd5,  1'b0, 16'h0000};
      tv[9]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 4'd0,  1'b0, 16'h0000};
      tv[10] = '{1'b0, 16'h0000, 1'b1, 1'b1, 4'd1,  1'b0, 16'h0001};
      tv[11] = '{1'b0, 16'h0000, 1'b1, 1'b1, 4'd12, 1'b0, 16'h001F};
      tv[12] = '{1'b0, 16'h0000, 1'b1, 1'b1, 4'd5,  1'b1, 16'h0000};
      tv[13] = '{1'b1, 16'h1111, 1'b0, 1'b0, 4'd0,  1'b0, 16'h0000};
      tv[14] = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd0,  1'b0, 16'h1111};
      tv[15] = '{1'b1, 16'h2222, 1'b1, 1'b0, 4'd0,  1'b0, 16'h2222};
      tv[16] = '{1'b0, 16'h0000, 1'b1, 1'b1, 4'd15, 1'b0, 16'h2222};
      tv[17] = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd0,  1'b1, 16'h0000};
      tv[18] = '{1'b1, 16'h3333, 1'b0, 1'b1, 4'd7,  1'b0, 16'h0000};
      tv[19] = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd3,  1'b0, 16'h3333};

      reset = 1'b1;
      bg_color = '0;
      hit_index = '0;
      idle();
      #1;
      chk("rst_valid", 32'(pix_valid_out), 32'd0);
      chk("rst_color", 32'(pixel_color), 32'd0);
      chk("rst_addr",  32'(color_addr), 32'd0);
      chk("rst_hitcnt", 32'(hit_count), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Table: vector k is sampled at the following posedge; its result is visible 3 negedges later.
      ea = '0;
      last_col = '0;
      for (int k = 0; k < N + 4; k++) begin
         @(negedge clk);
         chk($sformatf("addr[%0d]", k), 32'(color_addr), 32'(ea));
         if (k >= 3) begin
            chk($sformatf("valid[%0d]", k - 3), 32'(pix_valid_out), 32'(tv[k-3].v));
            if (tv[k-3].v) last_col = tv[k-3].exp;
            chk($sformatf("color[%0d]", k - 3), 32'(pixel_color), 32'(last_col));
         end
         if (k < N) begin
            drive(tv[k]);
            if (tv[k].v && tv[k].hit && (int'(tv[k].idx) < RC)) ea = tv[k].idx;
         end else begin
            idle();
         end
      end

      // Reset with two hit pixels in flight: neither may emerge, bg returns to 0.
      @(negedge clk); pix(1'b1, 4'd5, 1'b0);
      @(negedge clk); pix(1'b1, 4'd2, 1'b0);
      @(negedge clk); idle(); reset = 1'b1;
      #1;
      chk("midrst_addr", 32'(color_addr), 32'd0);
      chk("midrst_hitcnt", 32'(hit_count), 32'd0);
      @(negedge clk); reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("midrst_valid[%0d]", k), 32'(pix_valid_out), 32'd0);
         chk($sformatf("midrst_color[%0d]", k), 32'(pixel_color), 32'd0);
      end
      pix(1'b1, 4'd5, 1'b0);
      @(negedge clk); pix(1'b0, 4'd0, 1'b0);
      @(negedge clk); idle();
      @(negedge clk);
      chk("postrst_hit_valid", 32'(pix_valid_out), 32'd1);
      chk("postrst_hit_color", 32'(pixel_color), 32'hF800);
      @(negedge clk);
      chk("postrst_bg_valid", 32'(pix_valid_out), 32'd1);
      chk("postrst_bg_color", 32'(pixel_color), 32'h0000);
      @(negedge clk);
      chk("postrst_idle_valid", 32'(pix_valid_out), 32'd0);
      chk("postrst_hold_color", 32'(pixel_color), 32'h0000);

`ifdef GPU_HIT_COUNT_EN
      // Seven hits, one blanked, then frame_start latches the count.
      frame_start = 1'b1; bg_color = 16'h0000;
      @(negedge clk); idle();
      for (int i = 0; i < 7; i++) begin
         pix(1'b1, 4'd1, (i == 3) ? 1'b1 : 1'b0);
         @(negedge clk);
      end
      idle();
      repeat (6) @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk); idle();
      chk("hitcnt_frame", 32'(hit_count), 32'd6);
      frame_start = 1'b1;
      @(negedge clk); idle();
      chk("hitcnt_cleared", 32'(hit_count), 32'd0);
      pix(1'b1, 4'd1, 1'b0);
      @(negedge clk); pix(1'b1, 4'd2, 1'b0);
      @(negedge clk); idle();
      repeat (3) @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk); idle();
      chk("hitcnt_two", 32'(hit_count), 32'd2);
      pix(1'b1, 4'd1, 1'b0);
      @(negedge clk); pix(1'b1, 4'd2, 1'b0);
      @(negedge clk); idle(); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      chk("hitcnt_reset", 32'(hit_count), 32'd0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("hitcnt_rst_valid[%0d]", k), 32'(pix_valid_out), 32'd0);
      end
`else
      chk("hitcnt_tied", 32'(hit_count), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
